// File: rtl/miner_pkg.sv
// Shared widths and FSM state encoding for the nonce search block.
package miner_pkg;

    localparam int unsigned HEADER_W = 640;
    localparam int unsigned BASE_W   = 608;
    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned NONCE_W  = HEADER_W - BASE_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT      = 3'd2,
        CHECK     = 3'd3,
        DRAIN     = 3'd4,
        FOUND     = 3'd5,
        EXHAUSTED = 3'd6
    } state_t;

endpackage

// File: rtl/target_cmp.sv
// Strict 256-bit unsigned digest < target comparison.
module target_cmp
    import miner_pkg::*;
(
    input  logic [DIGEST_W-1:0] digest,
    input  logic [DIGEST_W-1:0] target,
    output logic                less_c
);

    // Purely combinational; equality is not a hit
    assign less_c = (digest < target);

endmodule

// File: rtl/nonce_scheduler.sv
// Walks nonces NONCE_START..NONCE_LAST through an external hash core and
// stops on the first digest strictly below the target.
// Optional watchdog on core latency: define NONCE_SCHED_TIMEOUT_EN.
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter logic [31:0] NONCE_START = 32'h0000_0000,
    parameter logic [31:0] NONCE_LAST  = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT_CYC = 1024
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [BASE_W-1:0]   header_base,
    input  logic [DIGEST_W-1:0] target,
    output logic                core_start,
    output logic [HEADER_W-1:0] core_header,
    input  logic                core_done,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                timeout_err,
    output logic [NONCE_W-1:0]  nonce_out,
    output logic [DIGEST_W-1:0] digest_out
);

    state_t              state;
    state_t              state_next;
    logic [BASE_W-1:0]   header_base_q;
    logic [DIGEST_W-1:0] target_q;
    logic [DIGEST_W-1:0] digest_q;
    logic [NONCE_W-1:0]  nonce;
    logic                launch_c;
    logic                capture_c;
    logic                hit_c;
    logic                last_c;
    logic                tmo_c;

    target_cmp u_target_cmp (
        .digest (digest_q),
        .target (target_q),
        .less_c (hit_c)
    );

    assign last_c      = (nonce == NONCE_LAST);
    assign core_header = {header_base_q, nonce};

`ifdef NONCE_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Watchdog restarts on each issue and counts only while waiting on the core
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT || state == DRAIN) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign tmo_c = (state == WAIT || state == DRAIN) && !core_done &&
                   (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Sticky timeout flag, cleared by the next launch
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (launch_c) begin
            timeout_err <= 1'b0;
        end else if (tmo_c) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_c       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus launch/capture strobes for the datapath
    always_comb begin
        state_next = state;
        launch_c   = 1'b0;
        capture_c  = 1'b0;
        case (state)
            IDLE, FOUND, EXHAUSTED: begin
                if (start) begin
                    state_next = ISSUE;
                    launch_c   = 1'b1;
                end
            end
            ISSUE: begin
                state_next = abort ? IDLE : WAIT;
            end
            WAIT: begin
                if (tmo_c) begin
                    state_next = IDLE;
                end else if (abort) begin
                    state_next = core_done ? IDLE : DRAIN;
                end else if (core_done) begin
                    state_next = CHECK;
                    capture_c  = 1'b1;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (hit_c) begin
                    state_next = FOUND;
                end else if (last_c) begin
                    state_next = EXHAUSTED;
                end else begin
                    state_next = ISSUE;
                end
            end
            DRAIN: begin
                if (core_done || tmo_c) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs, search context and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            core_start    <= 1'b0;
            busy          <= 1'b0;
            found         <= 1'b0;
            exhausted     <= 1'b0;
            header_base_q <= '0;
            target_q      <= '0;
            digest_q      <= '0;
            nonce         <= '0;
            nonce_out     <= '0;
            digest_out    <= '0;
        end else begin
            core_start <= (state_next == ISSUE);
            busy       <= (state_next inside {ISSUE, WAIT, CHECK, DRAIN});
            found      <= (state_next == FOUND);
            exhausted  <= (state_next == EXHAUSTED);
            if (launch_c) begin
                header_base_q <= header_base;
                target_q      <= target;
                nonce         <= NONCE_START;
            end else if (state == CHECK && state_next == ISSUE) begin
                nonce <= nonce + NONCE_W'(1);
            end
            if (capture_c) begin
                digest_q <= core_digest;
            end
            if (state == CHECK && state_next == FOUND) begin
                nonce_out  <= nonce;
                digest_out <= digest_q;
            end
        end
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a fixed-latency hash core model.
// Define NONCE_SCHED_TIMEOUT_EN to also exercise the watchdog.
`timescale 1ns/1ps
module tb_nonce_scheduler;

    localparam int unsigned TMO     = 8;
    localparam int          CORE_LAT = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [607:0] header_base = '0;
    logic [255:0] target = '0;
    logic         core_start;
    logic [639:0] core_header;
    logic         core_done = 1'b0;
    logic [255:0] core_digest = '0;
    logic         busy, found, exhausted, timeout_err;
    logic [31:0]  nonce_out;
    logic [255:0] digest_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nonce_scheduler #(
        .NONCE_START (32'h0),
        .NONCE_LAST  (32'h3),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .header_base (header_base),
        .target      (target),
        .core_start  (core_start),
        .core_header (core_header),
        .core_done   (core_done),
        .core_digest (core_digest),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .timeout_err (timeout_err),
        .nonce_out   (nonce_out),
        .digest_out  (digest_out)
    );

    // Hash core model state and launch bookkeeping
    int          core_mode = 0;
    bit          core_en = 1'b1;
    bit          pending = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] req_nonce = '0;
    int          n_starts = 0;
    int          n_double = 0;
    int          hdr_bad = 0;
    int          n_done = 0;
    bit          prev_cs = 1'b0;
    logic [31:0] seen[$];

    function automatic logic [255:0] model_digest(int mode, logic [31:0] n);
        case (mode)
            0:       return 256'd1;
            1:       return (n == 32'd2) ? 256'h0FF : 256'h1000;
            default: return (n == 32'd0) ? 256'h100 : 256'h0FF;
        endcase
    endfunction

    // Launch observer: counts pulses, records nonces, checks header and pulse width
    always @(posedge clk) begin
        if (core_start) begin
            n_starts++;
            seen.push_back(core_header[31:0]);
            if (core_header[639:32] !== header_base) hdr_bad++;
            if (prev_cs) n_double++;
        end
        prev_cs = core_start;
    end

    // Core model: answers CORE_LAT cycles after a launch unless disabled
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start && core_en) begin
            pending   <= 1'b1;
            lat_cnt   <= CORE_LAT;
            req_nonce <= core_header[31:0];
        end else if (pending) begin
            if (lat_cnt == 1) begin
                core_done   <= 1'b1;
                core_digest <= model_digest(core_mode, req_nonce);
                pending     <= 1'b0;
                n_done++;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_starts = 0;
        n_double = 0;
        hdr_bad  = 0;
        seen.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int i;
        i = 0;
        while (busy && i < max) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 256'(i < max), 256'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   256'(busy), 256'd0);
        chk({tag, "_found"},  256'(found), 256'd0);
        chk({tag, "_exh"},    256'(exhausted), 256'd0);
        chk({tag, "_tmo"},    256'(timeout_err), 256'd0);
        chk({tag, "_cs"},     256'(core_start), 256'd0);
        chk({tag, "_nonce"},  256'(nonce_out), 256'd0);
        chk({tag, "_digest"}, digest_out, 256'd0);
        chk({tag, "_hdr"},    256'(core_header != '0), 256'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish, got running expected done");
        $fatal(1, "bench timeout");
    end

    initial begin
        int snap;
        bit early_idle;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst");

        // Exhaustion: target 0, every digest is 1
        header_base = {19{32'hA5A5_1234}};
        target      = 256'd0;
        core_mode   = 0;
        clear_counts();
        pulse_start();
        wait_idle("s1_done", 200);
        chk("s1_starts", 256'(n_starts), 256'd4);
        chk("s1_nseen", 256'(seen.size()), 256'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("s1_nonce%0d", i), 256'((i < seen.size()) ? seen[i] : 32'hDEAD_BEEF), 256'(i));
        chk("s1_exh", 256'(exhausted), 256'd1);
        chk("s1_found", 256'(found), 256'd0);
        chk("s1_nonce_out", 256'(nonce_out), 256'd0);
        chk("s1_hdr", 256'(hdr_bad), 256'd0);
        repeat (5) @(negedge clk);
        chk("s1_exh_hold", 256'(exhausted), 256'd1);

        // Hit on nonce 2; a start while busy must be ignored
        header_base = {19{32'h0BAD_F00D}};
        target      = 256'h100;
        core_mode   = 1;
        clear_counts();
        pulse_start();
        chk("s2_exh_clr", 256'(exhausted), 256'd0);
        repeat (9) @(negedge clk);
        chk("s2_busy_mid", 256'(busy), 256'd1);
        pulse_start();
        wait_idle("s2_done", 200);
        chk("s2_found", 256'(found), 256'd1);
        chk("s2_exh", 256'(exhausted), 256'd0);
        chk("s2_nonce_out", 256'(nonce_out), 256'd2);
        chk("s2_digest_out", digest_out, 256'h0FF);
        chk("s2_starts", 256'(n_starts), 256'd3);
        chk("s2_hdr", 256'(hdr_bad), 256'd0);
        repeat (5) @(negedge clk);
        chk("s2_hold_nonce", 256'(nonce_out), 256'd2);

        // Digest equal to target is not a hit; nonce 1 then hits
        core_mode = 2;
        clear_counts();
        pulse_start();
        chk("s3_found_clr", 256'(found), 256'd0);
        wait_idle("s3_done", 200);
        chk("s3_found", 256'(found), 256'd1);
        chk("s3_nonce_out", 256'(nonce_out), 256'd1);
        chk("s3_digest_out", digest_out, 256'h0FF);
        chk("s3_starts", 256'(n_starts), 256'd2);

        // Abort two cycles into WAIT; core answers three cycles later
        core_mode = 0;
        target    = 256'd0;
        clear_counts();
        pulse_start();
        chk("s4_cs", 256'(core_start), 256'd1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        early_idle = 1'b0;
        for (int i = 0; i < 20 && !core_done; i++) begin
            if (!busy) early_idle = 1'b1;
            @(negedge clk);
        end
        chk("s4_done_seen", 256'(core_done), 256'd1);
        chk("s4_busy_drain", 256'(busy | early_idle ? {255'd0, busy & !early_idle} : 256'd0), 256'd1);
        @(negedge clk);
        chk("s4_idle", 256'(busy), 256'd0);
        chk("s4_found", 256'(found), 256'd0);
        chk("s4_exh", 256'(exhausted), 256'd0);
        repeat (20) @(negedge clk);
        chk("s4_starts", 256'(n_starts), 256'd1);
        chk("s4_still_idle", 256'(busy), 256'd0);

        // Reset mid-WAIT with a stray core_done afterwards
        header_base = {19{32'h1357_9BDF}};
        clear_counts();
        snap = n_done;
        pulse_start();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("s5_stray_done", 256'(n_done - snap), 256'd1);
        chk_reset_outputs("s5");
        chk("s5_starts", 256'(n_starts), 256'd1);

`ifdef NONCE_SCHED_TIMEOUT_EN
        // Silent core: watchdog fires eight cycles after entering WAIT
        core_en = 1'b0;
        pulse_start();
        repeat (8) @(negedge clk);
        chk("s6_busy_pre", 256'(busy), 256'd1);
        chk("s6_tmo_pre", 256'(timeout_err), 256'd0);
        @(negedge clk);
        chk("s6_busy", 256'(busy), 256'd0);
        chk("s6_tmo", 256'(timeout_err), 256'd1);
        core_en = 1'b1;
        pulse_start();
        chk("s6_tmo_clr", 256'(timeout_err), 256'd0);
        wait_idle("s6_done", 200);
`else
        // Silent core: without the watchdog the search waits indefinitely
        core_en = 1'b0;
        pulse_start();
        repeat (50) @(negedge clk);
        chk("s6_busy_wait", 256'(busy), 256'd1);
        chk("s6_tmo_tied", 256'(timeout_err), 256'd0);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        core_en = 1'b1;
        @(negedge clk);
        chk("s6_busy_rst", 256'(busy), 256'd0);
`endif

        chk("pulse_width", 256'(n_double), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 SHALL have parameter NONCE_START, default 32'h0000_0000, first nonce tried.
REQ-002 SHALL have parameter NONCE_LAST, default 32'hFFFF_FFFF, last nonce tried (NONCE_LAST >= NONCE_START).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, core watchdog limit in cycles (used only with the watchdog feature).
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that launches a search.
REQ-007 SHALL have port abort  in  1  one-cycle pulse that cancels a search.
REQ-008 SHALL have port header_base  in  608  header bits above the nonce.
REQ-009 SHALL have port target  in  256  difficulty target, unsigned.
REQ-010 SHALL have port core_start  out  1  one-cycle launch pulse to the hash core.
REQ-011 SHALL have port core_header  out  640  {header_base_q, nonce} to the hash core.
REQ-012 SHALL have port core_done  in  1  one-cycle pulse, core_digest valid.
REQ-013 SHALL have port core_digest  in  256  hash core result.
REQ-014 SHALL have ports busy, found, exhausted, timeout_err  out  1 each  status flags.
REQ-015 SHALL have ports nonce_out  out  32 and digest_out  out  256  winning nonce and digest.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, CHECK, DRAIN, FOUND, EXHAUSTED.
REQ-017 SHALL, in IDLE, FOUND or EXHAUSTED on start, latch header_base and target, set nonce = NONCE_START, clear found/exhausted/timeout_err and go to ISSUE.
REQ-018 SHALL assert core_start for exactly one cycle in ISSUE, then enter WAIT.
REQ-019 SHALL, in WAIT on core_done, register core_digest and enter CHECK on the next cycle.
REQ-020 SHALL, in CHECK, go to FOUND if digest < target (strict, 256-bit unsigned), loading nonce_out and digest_out.
REQ-021 SHALL, in CHECK without a hit, go to EXHAUSTED if nonce == NONCE_LAST, else nonce increments by 1 and the FSM goes to ISSUE (three cycles of overhead per hash plus core latency).
REQ-022 SHALL never wrap nonce past NONCE_LAST; 32-bit increment is used only below NONCE_LAST.
REQ-023 SHALL hold core_header stable from ISSUE until core_done is sampled.
REQ-024 SHALL assert busy in ISSUE, WAIT, CHECK and DRAIN, and in no other state.
REQ-025 SHALL, on abort in ISSUE or CHECK, go to IDLE; on abort in WAIT, go to DRAIN, wait for core_done, discard the digest, then go to IDLE.
REQ-026 SHALL ignore start while busy and ignore abort in IDLE, FOUND and EXHAUSTED.
REQ-027 SHALL give abort priority over start in the same cycle; when core_done and abort coincide in WAIT, the FSM goes directly to IDLE with the digest discarded.
REQ-028 SHALL hold found/exhausted and nonce_out/digest_out until the next start or reset.

Reset
REQ-029 SHALL, on reset, force IDLE with core_start=0, busy=0, found=0, exhausted=0, timeout_err=0, nonce_out=0, digest_out=0, core_header=0 and internal nonce=0, regardless of current state, including mid-WAIT; a late core_done after reset is ignored.

Configuration
REQ-030 SHALL, with macro NONCE_SCHED_TIMEOUT_EN defined, count cycles in WAIT and DRAIN; if the count reaches TIMEOUT_CYC without core_done, set timeout_err and go to IDLE; timeout_err clears on start or reset.
REQ-031 SHALL, without NONCE_SCHED_TIMEOUT_EN, contain no counter, wait indefinitely, and tie timeout_err to 0.

Structure
REQ-032 SHALL take the state enum, the header width (640), the base width (608) and the digest width (256) from shared package miner_pkg.
REQ-033 SHALL place the 256-bit less-than comparison in sub-module target_cmp, which is combinational and instantiated once.

Verification
REQ-034 SHALL cover this scenario: NONCE_START=0, NONCE_LAST=3, target=0, model core returns digest=1 after 5 cycles -> four core_start pulses for nonces 0..3, then exhausted=1 and found=0.
REQ-035 SHALL cover this scenario: target=256'h100, model returns 256'h0FF for nonce 2 only -> found=1, nonce_out=2, digest_out=256'h0FF, exactly three core_start pulses.
REQ-036 SHALL cover this scenario: digest == target (256'h100) -> not a hit, and the search continues to the next nonce.
REQ-037 SHALL cover this scenario: abort two cycles into WAIT, core_done arriving three cycles later -> busy stays 1 until core_done, then IDLE, found=0, and no further core_start.
REQ-038 SHALL cover this scenario: reset asserted mid-WAIT, followed by a stray core_done -> all outputs at reset values and the FSM stays in IDLE.
REQ-039 SHALL cover this scenario: with NONCE_SCHED_TIMEOUT_EN, TIMEOUT_CYC=8 and a core that never responds -> timeout_err=1 and busy=0 eight cycles after entering WAIT.
